// File: rtl/des_data_buffer.sv
// Word FIFOs, key registers and block pack/unpack between the APB decoder and the 3DES core.
// Counts are registered, data_out and block_* come straight from storage; one block in flight, output space reserved before issue.
module des_data_buffer #(
    parameter int IN_DEPTH  = 24,
    parameter int OUT_DEPTH = 24
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [2:0]  mode,
    input  logic [31:0] PWDATA,
    output logic [4:0]  data_in_cnt,
    output logic [4:0]  data_out_cnt,
    output logic [31:0] data_out,
    output logic [63:0] key1,
    output logic [63:0] key2,
    output logic        block_valid,
    output logic [63:0] block_data,
    output logic        block_enc,
    input  logic        block_ready,
    input  logic        result_valid,
    input  logic [63:0] result_data
);

    localparam logic [2:0] MODE_WR_ENC = 3'd1;
    localparam logic [2:0] MODE_WR_DEC = 3'd2;
    localparam logic [2:0] MODE_KEY1   = 3'd3;
    localparam logic [2:0] MODE_KEY2   = 3'd4;
    localparam logic [2:0] MODE_CLEAR  = 3'd5;
    localparam logic [2:0] MODE_READ   = 3'd6;

    localparam logic [4:0] IN_FULL  = 5'(IN_DEPTH);
    localparam logic [4:0] IN_LAST  = 5'(IN_DEPTH - 1);
    localparam logic [4:0] OUT_LIM  = 5'(OUT_DEPTH - 2);
    localparam logic [4:0] OUT_LAST = 5'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

    function automatic logic [4:0] ptr_inc(input logic [4:0] p, input logic [4:0] last);
        return (p == last) ? 5'd0 : p + 5'd1;
    endfunction

    logic [32:0] in_mem_q  [IN_DEPTH];
    logic [31:0] out_mem_q [OUT_DEPTH];

    state_e      state_q, state_d;
    logic [4:0]  in_wp_q, in_wp_d, in_rp_q, in_rp_d, in_cnt_q, in_cnt_d;
    logic [4:0]  out_wp_q, out_wp_d, out_rp_q, out_rp_d, out_cnt_q, out_cnt_d;
    logic [63:0] key1_q, key1_d, key2_q, key2_d;
    logic        key1_tog_q, key1_tog_d, key2_tog_q, key2_tog_d;

    logic        clr, wr_in, rd_out, in_pop, out_push, key_pend;
    logic [4:0]  in_rp_nxt;

    assign clr       = (mode == MODE_CLEAR);
    assign wr_in     = ((mode == MODE_WR_ENC) || (mode == MODE_WR_DEC)) && (in_cnt_q != IN_FULL);
    assign rd_out    = (mode == MODE_READ) && (out_cnt_q != 5'd0);
    assign key_pend  = key1_tog_q | key2_tog_q;
    assign in_rp_nxt = ptr_inc(in_rp_q, IN_LAST);

    assign data_in_cnt  = in_cnt_q;
    assign data_out_cnt = out_cnt_q;
    assign data_out     = (out_cnt_q == 5'd0) ? 32'd0 : out_mem_q[out_rp_q];
    assign key1         = key1_q;
    assign key2         = key2_q;
    // The read pointer only moves in ISSUE by acceptance, so the head pair is stable while offered.
    assign block_data   = {in_mem_q[in_rp_q][31:0], in_mem_q[in_rp_nxt][31:0]};
    assign block_enc    = in_mem_q[in_rp_q][32];

    always_comb begin
        state_d     = state_q;
        block_valid = (state_q == ISSUE);
        in_pop      = 1'b0;
        out_push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!clr && (in_cnt_q >= 5'd2) && (out_cnt_q <= OUT_LIM) && !key_pend)
                    state_d = ISSUE;
            end
            ISSUE: begin
                if (block_ready) begin
                    in_pop  = 1'b1;
                    state_d = clr ? DRAIN : WAIT;
                end else if (clr) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (result_valid) begin
                    out_push = !clr;
                    state_d  = IDLE;
                end else if (clr) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (result_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_wp_d    = in_wp_q;
        in_rp_d    = in_rp_q;
        in_cnt_d   = in_cnt_q;
        out_wp_d   = out_wp_q;
        out_rp_d   = out_rp_q;
        out_cnt_d  = out_cnt_q;
        key1_d     = key1_q;
        key2_d     = key2_q;
        key1_tog_d = key1_tog_q;
        key2_tog_d = key2_tog_q;
        if (clr) begin
            in_wp_d    = 5'd0;
            in_rp_d    = 5'd0;
            in_cnt_d   = 5'd0;
            out_wp_d   = 5'd0;
            out_rp_d   = 5'd0;
            out_cnt_d  = 5'd0;
            key1_tog_d = 1'b0;
            key2_tog_d = 1'b0;
        end else begin
            if (wr_in)    in_wp_d  = ptr_inc(in_wp_q, IN_LAST);
            if (in_pop)   in_rp_d  = ptr_inc(in_rp_nxt, IN_LAST);
            if (out_push) out_wp_d = ptr_inc(ptr_inc(out_wp_q, OUT_LAST), OUT_LAST);
            if (rd_out)   out_rp_d = ptr_inc(out_rp_q, OUT_LAST);
            in_cnt_d  = in_cnt_q + {4'd0, wr_in} - (in_pop ? 5'd2 : 5'd0);
            out_cnt_d = out_cnt_q + (out_push ? 5'd2 : 5'd0) - {4'd0, rd_out};
            if (mode == MODE_KEY1) begin
                if (key1_tog_q) key1_d[31:0]  = PWDATA;
                else            key1_d[63:32] = PWDATA;
                key1_tog_d = !key1_tog_q;
            end
            if (mode == MODE_KEY2) begin
                if (key2_tog_q) key2_d[31:0]  = PWDATA;
                else            key2_d[63:32] = PWDATA;
                key2_tog_d = !key2_tog_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_in && !clr)
            in_mem_q[in_wp_q] <= {(mode == MODE_WR_ENC), PWDATA};
        if (out_push) begin
            out_mem_q[out_wp_q]                     <= result_data[63:32];
            out_mem_q[ptr_inc(out_wp_q, OUT_LAST)]  <= result_data[31:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            in_wp_q    <= 5'd0;
            in_rp_q    <= 5'd0;
            in_cnt_q   <= 5'd0;
            out_wp_q   <= 5'd0;
            out_rp_q   <= 5'd0;
            out_cnt_q  <= 5'd0;
            key1_q     <= 64'd0;
            key2_q     <= 64'd0;
            key1_tog_q <= 1'b0;
            key2_tog_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_wp_q    <= in_wp_d;
            in_rp_q    <= in_rp_d;
            in_cnt_q   <= in_cnt_d;
            out_wp_q   <= out_wp_d;
            out_rp_q   <= out_rp_d;
            out_cnt_q  <= out_cnt_d;
            key1_q     <= key1_d;
            key2_q     <= key2_d;
            key1_tog_q <= key1_tog_d;
            key2_tog_q <= key2_tog_d;
        end
    end

endmodule

// File: tb/tb_des_data_buffer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based reference model.
module tb_des_data_buffer;

    localparam int IN_DEPTH  = 24;
    localparam int OUT_DEPTH = 24;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [2:0]  mode = '0;
    logic [31:0] PWDATA = '0;
    logic [4:0]  data_in_cnt, data_out_cnt;
    logic [31:0] data_out;
    logic [63:0] key1, key2, block_data;
    logic        block_valid, block_enc;
    logic        block_ready = 1'b0;
    logic        result_valid = 1'b0;
    logic [63:0] result_data = '0;

    int total = 0;
    int bad   = 0;

    des_data_buffer #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .mode(mode), .PWDATA(PWDATA),
        .data_in_cnt(data_in_cnt), .data_out_cnt(data_out_cnt), .data_out(data_out),
        .key1(key1), .key2(key2), .block_valid(block_valid), .block_data(block_data),
        .block_enc(block_enc), .block_ready(block_ready), .result_valid(result_valid),
        .result_data(result_data)
    );

    always #5 clk = ~clk;

    // Reference model: word queues, keys, half-written flags, block phase (0 idle,1 offered,2 in core,3 discard)
    logic [32:0] in_q[$];
    logic [31:0] out_q[$];
    logic [63:0] k1, k2;
    bit          t1, t2;
    int          ph;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_q.delete(); out_q.delete();
        k1 = '0; k2 = '0; t1 = 0; t2 = 0; ph = 0;
    endtask

    task automatic check_outputs();
        chk("in_cnt",  64'(data_in_cnt),  64'(in_q.size()));
        chk("out_cnt", 64'(data_out_cnt), 64'(out_q.size()));
        chk("data_out", 64'(data_out), (out_q.size() > 0) ? 64'(out_q[0]) : 64'd0);
        chk("key1", key1, k1);
        chk("key2", key2, k2);
        chk("block_valid", 64'(block_valid), 64'(ph == 1));
        if (ph == 1) begin
            chk("block_data", block_data, {in_q[0][31:0], in_q[1][31:0]});
            chk("block_enc", 64'(block_enc), 64'(in_q[0][32]));
        end
    endtask

    task automatic model_edge(input logic [2:0] m, input logic [31:0] d, input logic rdy,
                              input logic rv, input logic [63:0] rd);
        bit clr  = (m == 3'd5);
        bit acc  = (ph == 1) && rdy;
        bit full = (in_q.size() >= IN_DEPTH);
        int nph  = ph;
        case (ph)
            0: if (!clr && in_q.size() >= 2 && out_q.size() <= OUT_DEPTH - 2 && !(t1 || t2)) nph = 1;
            1: nph = acc ? (clr ? 3 : 2) : (clr ? 0 : 1);
            2: nph = rv ? 0 : (clr ? 3 : 2);
            default: nph = rv ? 0 : 3;
        endcase
        if (m == 3'd3) begin
            if (t1) k1[31:0] = d; else k1[63:32] = d;
            t1 = !t1;
        end
        if (m == 3'd4) begin
            if (t2) k2[31:0] = d; else k2[63:32] = d;
            t2 = !t2;
        end
        if (clr) begin
            in_q.delete(); out_q.delete(); t1 = 0; t2 = 0;
        end else begin
            if (acc) begin
                void'(in_q.pop_front());
                void'(in_q.pop_front());
            end
            if ((m == 3'd1 || m == 3'd2) && !full) in_q.push_back({(m == 3'd1), d});
            if (m == 3'd6 && out_q.size() > 0) void'(out_q.pop_front());
            if (ph == 2 && rv) begin
                out_q.push_back(rd[63:32]);
                out_q.push_back(rd[31:0]);
            end
        end
        ph = nph;
    endtask

    // One clock: drive, check pre-edge outputs, advance model, then sample point #1 after edge.
    task automatic step(input logic [2:0] m, input logic [31:0] d, input logic rdy,
                        input logic rv, input logic [63:0] rd);
        mode = m; PWDATA = d; block_ready = rdy; result_valid = rv; result_data = rd;
        #1;
        check_outputs();
        model_edge(m, d, rdy, rv, rd);
        @(posedge clk);
        #1;
        mode = '0; PWDATA = '0; block_ready = 1'b0; result_valid = 1'b0; result_data = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_cnt"},  64'(data_in_cnt), 64'd0);
        chk({tag, "_out_cnt"}, 64'(data_out_cnt), 64'd0);
        chk({tag, "_dout"},    64'(data_out), 64'd0);
        chk({tag, "_bvalid"},  64'(block_valid), 64'd0);
        chk({tag, "_key1"},    key1, 64'd0);
        chk({tag, "_key2"},    key2, 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        int r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: two encrypt words form one block
        step(3'd1, 32'h01234567, 0, 0, '0);
        step(3'd1, 32'h89ABCDEF, 0, 0, '0);
        step(3'd0, '0, 0, 0, '0);
        chk("t1_bvalid", 64'(block_valid), 64'd1);
        chk("t1_bdata", block_data, 64'h0123456789ABCDEF);
        chk("t1_benc", 64'(block_enc), 64'd1);
        step(3'd0, '0, 1, 0, '0);
        chk("t1_in_cnt", 64'(data_in_cnt), 64'd0);

        // 2: result unpacked high word first
        step(3'd0, '0, 0, 1, 64'hDEADBEEFCAFEF00D);
        chk("t2_out_cnt", 64'(data_out_cnt), 64'd2);
        chk("t2_head0", 64'(data_out), 64'hDEADBEEF);
        step(3'd6, '0, 0, 0, '0);
        chk("t2_head1", 64'(data_out), 64'hCAFEF00D);
        step(3'd6, '0, 0, 0, '0);
        chk("t2_out_cnt0", 64'(data_out_cnt), 64'd0);

        // 3: saturation of the input FIFO
        for (int i = 0; i < 25; i++) step(3'd2, 32'h1000 + i, 0, 0, '0);
        chk("t3_in_sat", 64'(data_in_cnt), 64'd24);
        chk("t3_benc", 64'(block_enc), 64'd0);
        chk("t3_bvalid", 64'(block_valid), 64'd1);
        step(3'd5, '0, 0, 0, '0);
        chk("t3_clr_in", 64'(data_in_cnt), 64'd0);

        // 4: half-written key holds off issue
        step(3'd3, 32'h1111, 0, 0, '0);
        step(3'd1, 32'hA5A5A5A5, 0, 0, '0);
        step(3'd1, 32'h5A5A5A5A, 0, 0, '0);
        repeat (3) step(3'd0, '0, 0, 0, '0);
        chk("t4_held", 64'(block_valid), 64'd0);
        step(3'd3, 32'h2222, 0, 0, '0);
        chk("t4_key1", key1, 64'h0000111100002222);
        step(3'd0, '0, 0, 0, '0);
        chk("t4_bvalid", 64'(block_valid), 64'd1);

        // 5: clear while a block is in the core discards its result
        step(3'd0, '0, 1, 0, '0);
        step(3'd5, '0, 0, 0, '0);
        chk("t5_in_cnt", 64'(data_in_cnt), 64'd0);
        chk("t5_out_cnt", 64'(data_out_cnt), 64'd0);
        step(3'd0, '0, 0, 1, 64'h1122334455667788);
        chk("t5_discard", 64'(data_out_cnt), 64'd0);
        step(3'd1, 32'h1, 0, 0, '0);
        step(3'd1, 32'h2, 0, 0, '0);
        step(3'd0, '0, 0, 0, '0);
        chk("t5_idle_again", 64'(block_valid), 64'd1);
        step(3'd5, '0, 0, 0, '0);

        // 6: fill output to 22, then read and result push on one edge
        for (int i = 0; i < 600 && out_q.size() < 22; i++) begin
            rd = {$urandom(), $urandom()};
            if (ph == 0 && in_q.size() < 2) step(3'd1, $urandom(), 1, 1, rd);
            else                             step(3'd0, '0, 1, 1, rd);
        end
        chk("t6_fill", 64'(data_out_cnt), 64'd22);
        while (in_q.size() < 2) step(3'd2, $urandom(), 0, 0, '0);
        for (int i = 0; i < 20 && ph != 2; i++) step(3'd0, '0, 1, 0, '0);
        chk("t6_in_core", 64'(ph), 64'd2);
        step(3'd6, '0, 0, 1, {$urandom(), $urandom()});
        chk("t6_out_cnt", 64'(data_out_cnt), 64'd23);
        chk("t6_head", 64'(data_out), 64'(out_q[0]));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] m;
            r = $urandom_range(0, 99);
            if      (r < 30) m = 3'($urandom_range(1, 2));
            else if (r < 42) m = 3'd6;
            else if (r < 44) m = 3'd5;
            else if (r < 50) m = 3'($urandom_range(3, 4));
            else             m = 3'd0;
            step(m, $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 {$urandom(), $urandom()});
            if (i == 1500) begin
                n_rst = 1'b0;
                #2;
                model_reset();
                check_reset("mid_rst");
                n_rst = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
